fg_trapezoid_gen: RTL
=====================

# fg_trapezoid_gen

Parametrised trapezoid/pulse waveform generator for the function-generator datapath. It owns its own period counter and double-buffers its settings in shadow registers that reload only at period start. It drives a RISE/ON/FALL envelope with a single shared saturating adder, and supports continuous or triggered one-shot operation. It sits between the register file and the output DAC formatter, advancing only on the shared `clk_en_i` tick.

## Interface
- `COUNTER_BITWIDTH`, 32: width of period and on-time counts (in ticks).
- `WAVEFORM_BITWIDTH`, 16: width of slope and amplitude; the output is one bit wider.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `clk_en_i` input 1: tick enable; all state advances only on cycles where it is 1.
- `enable_i` input 1: run request.
- `one_shot_i` input 1: 1 = one period per trigger; 0 = continuous.
- `trig_i` input 1: one-shot start, sampled on ticks.
- `period_i` input COUNTER_BITWIDTH: period length in ticks.
- `on_time_i` input COUNTER_BITWIDTH: count at which FALL is forced.
- `k_rise_i`, `k_fall_i` input WAVEFORM_BITWIDTH each: unsigned step per tick.
- `amplitude_i` input WAVEFORM_BITWIDTH: unsigned plateau level.
- `out_o` output WAVEFORM_BITWIDTH+1: signed waveform value, always in [0, 2^W−1].
- `state_o` output 2: IDLE=0, RISE=1, ON=2, FALL=3.
- `busy_o` output 1: run flag.
- `period_start_o` output 1: pulse on each shadow load.

## Operation
- **Registers:** `run`, `cnt`, `state`, `val`, and shadows `per_s`, `on_s`, `kr_s`, `kf_s`, `amp_s`. Reset clears all of them to 0; every output resets to 0.
- **Start condition (stopped, tick):**
  - Continuous: `enable_i`=1.
  - One-shot: `enable_i`=1 and `trig_i`=1. `trig_i` is ignored while running.
- **Load tick:** a start tick, or a tick with `run`=1 and `cnt`=0. On a load tick:
  - Latch the shadows. `per_s` = max(`period_i`, 2); `on_s` = max(`on_time_i`, 1); `amp_s` is zero-extended.
  - `state`←RISE, `val`←0, `cnt`←1, `run`←1.
- **Running tick with `cnt`≠0:** apply the following in priority order.
  1. `cnt`=`per_s`−1 (end of period): `val`←0, `state`←IDLE, `cnt`←0. Set `run`←0 if `one_shot_i`=1 or `enable_i`=0; otherwise the next tick is a load tick.
  2. `cnt`=`on_s` and `state`∈{RISE, ON}: `state`←FALL, `val`←max(`val`−`kf_s`, 0); if the result is 0, `state`←IDLE.
  3. Otherwise, by state:
     - RISE: `val`←min(`val`+`kr_s`, `amp_s`); on reaching `amp_s`, `state`←ON.
     - ON: `val`←`amp_s`.
     - FALL: `val`←max(`val`−`kf_s`, 0); at 0, `state`←IDLE.
     - IDLE: `val`←0 and hold until the end of the period.
  4. `cnt`←`cnt`+1, except in case 1.
- **Arithmetic:**
  - One adder only. Its operand is +`kr_s` in RISE, −`kf_s` otherwise.
  - The sum is W+2 bits signed, so there is no wrap; clamping is applied to the sum.
  - `kr_s`=0 holds RISE until the on-time. `amp_s`=0 moves RISE→ON at 0 on the first rise tick.
- **Precedence:**
  - End-of-period overrides on-time.
  - If `on_s` ≥ `per_s`−1, FALL is never forced and the waveform drops to 0 at the end of the period.
- **Gating:**
  - Input changes mid-period have no effect until the next load tick.
  - `enable_i` falling mid-period completes the current period, then stops.
  - `clk_en_i`=0: everything holds, including `trig_i` sampling.

## Timing
- All outputs are registered. `out_o` equals `val`, `state_o` equals `state`, `busy_o` equals `run`.
- Each value appears on the clk edge of the tick that computes it.
- `period_start_o` is registered: high for exactly one clk cycle after each load tick, cleared on the next clk edge regardless of `clk_en_i`.
- Start latency: the trigger/enable tick produces `busy_o`=1, `state`=RISE, `out_o`=0; the first nonzero value arrives on the following tick.
- Period length is exactly `per_s` ticks (`cnt` 0 … `per_s`−1).
- Async reset mid-period: outputs go to 0 immediately. After release, a fresh start condition is required.

## Test plan
- **Basic continuous run.** Continuous, `clk_en_i`=1, `period_i`=10, `on_time_i`=6, `k_rise_i`=100, `k_fall_i`=50, `amplitude_i`=250.
  - Required `out_o` per tick: 0, 100, 200, 250, 250, 250, 200, 150, 100, 0, then repeating.
  - `state_o` must follow the envelope; `period_start_o` must pulse every 10 ticks.
- **Clamping.** `k_rise_i`=300, `amplitude_i`=250, `k_fall_i`=500, `on_time_i`=3, `period_i`=8.
  - Required `out_o`: 0, 250, 250, 0, 0, 0, 0, 0.
  - `state` must be ON at count 1 and IDLE at count 3; the value never goes negative.
- **One-shot.** One-shot, `trig_i` pulsed at tick 0 and again at tick 4, `period_i`=6.
  - Exactly one period must run; the second trigger is ignored; `busy_o` must drop after 6 ticks.
  - A third trigger while idle must restart the period.
- **Shadow buffering.** Change `amplitude_i` 250→1000 at count 3.
  - The current period must keep its plateau at 250; the next period must plateau at 1000.
- **Tick gating and reset.**
  - `clk_en_i` high every 3rd cycle: the value sequence must match the basic run at one third the rate, and `period_start_o` must stay one clk wide.
  - Assert `rst_i` at count 4: all outputs must read 0 before the next edge.
- **Degenerate settings.**
  - `period_i`=0: must behave as 2 (load, then end).
  - `on_time_i`=0: FALL must be forced at count 1.
  - `on_time_i`=50 with `period_i`=10: the value must drop to 0 only at count 9.

Source files
------------

// File: rtl/fg_trapezoid_gen.sv
// -----------------------------------------------------------------------------
// fg_trapezoid_gen
//
// Trapezoid / pulse waveform generator for the function-generator datapath.
// A free-running period counter drives a RISE -> ON -> FALL envelope. Settings
// are captured into shadow registers only at period start, so register-file
// writes mid-period never disturb the waveform being played. A single shared
// saturating adder produces both the rising and the falling slope.
//
// All state advances only on cycles where clk_en_i is 1 (the shared datapath
// tick). There is no valid/ready handshake: inputs are sampled on ticks and
// outputs are registered values that change on the clk edge of a tick.
//
// Ports
//   clk_i, rst_i     clock, asynchronous active-high reset
//   clk_en_i         tick enable
//   enable_i         run request (continuous start, or arm for one-shot)
//   one_shot_i       1 = one period per trig_i, 0 = continuous
//   trig_i           one-shot start, ignored while running
//   period_i         period length in ticks (values below 2 act as 2)
//   on_time_i        count at which FALL is forced (0 acts as 1)
//   k_rise_i         unsigned rise step per tick
//   k_fall_i         unsigned fall step per tick
//   amplitude_i      unsigned plateau level
//   out_o            signed waveform value, always in [0, 2^W-1]
//   state_o          envelope state: IDLE=0, RISE=1, ON=2, FALL=3
//   busy_o           run flag
//   period_start_o   one clk pulse after each shadow load
// -----------------------------------------------------------------------------
module fg_trapezoid_gen #(
   parameter int COUNTER_BITWIDTH  = 32,
   parameter int WAVEFORM_BITWIDTH = 16
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                clk_en_i,
   input  logic                                enable_i,
   input  logic                                one_shot_i,
   input  logic                                trig_i,
   input  logic [COUNTER_BITWIDTH-1:0]         period_i,
   input  logic [COUNTER_BITWIDTH-1:0]         on_time_i,
   input  logic [WAVEFORM_BITWIDTH-1:0]        k_rise_i,
   input  logic [WAVEFORM_BITWIDTH-1:0]        k_fall_i,
   input  logic [WAVEFORM_BITWIDTH-1:0]        amplitude_i,
   output logic signed [WAVEFORM_BITWIDTH:0]   out_o,
   output logic [1:0]                          state_o,
   output logic                                busy_o,
   output logic                                period_start_o
);

   localparam int CW = COUNTER_BITWIDTH;
   localparam int WW = WAVEFORM_BITWIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RISE = 2'd1,
      ST_ON   = 2'd2,
      ST_FALL = 2'd3
   } state_t;

   // Registered state
   logic            r_run;
   logic [CW-1:0]   r_cnt;
   state_t          r_state;
   logic [WW-1:0]   r_val;
   logic [CW-1:0]   r_per_s;
   logic [CW-1:0]   r_on_s;
   logic [WW-1:0]   r_kr_s;
   logic [WW-1:0]   r_kf_s;
   logic [WW-1:0]   r_amp_s;
   logic            r_pstart;

   // Next-state values
   logic            w_run_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   state_t          w_state_nxt;
   logic [WW-1:0]   w_val_nxt;
   logic [CW-1:0]   w_per_nxt;
   logic [CW-1:0]   w_on_nxt;
   logic [WW-1:0]   w_kr_nxt;
   logic [WW-1:0]   w_kf_nxt;
   logic [WW-1:0]   w_amp_nxt;
   logic            w_pstart_nxt;

   // Control decode
   logic            w_start;
   logic            w_load;
   logic            w_end;
   logic            w_force_fall;
   logic            w_rising;

   // Shared adder, two bits wider than the waveform so it can neither wrap
   // past 2^W-1 nor below zero; clamping looks at the full signed sum.
   logic signed [WW+1:0] w_operand;
   logic signed [WW+1:0] w_sum;
   logic signed [WW+1:0] w_amp_ext;
   logic                 w_sum_le0;
   logic                 w_sum_ge_amp;

   assign w_start      = !r_run && enable_i && (!one_shot_i || trig_i);
   assign w_load       = w_start || (r_run && (r_cnt == '0));
   assign w_end        = (r_cnt == (r_per_s - CW'(1)));
   assign w_force_fall = (r_cnt == r_on_s) &&
                         ((r_state == ST_RISE) || (r_state == ST_ON));
   // A forced fall out of RISE must subtract, so the rise operand is only
   // selected when no fall is being forced this tick.
   assign w_rising     = (r_state == ST_RISE) && !w_force_fall;

   assign w_operand    = w_rising ? $signed({2'b00, r_kr_s})
                                  : -$signed({2'b00, r_kf_s});
   assign w_sum        = $signed({2'b00, r_val}) + w_operand;
   assign w_amp_ext    = $signed({2'b00, r_amp_s});
   assign w_sum_le0    = w_sum[WW+1] || (w_sum == '0);
   assign w_sum_ge_amp = (w_sum >= w_amp_ext);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_run    <= 1'b0;
         r_cnt    <= '0;
         r_state  <= ST_IDLE;
         r_val    <= '0;
         r_per_s  <= '0;
         r_on_s   <= '0;
         r_kr_s   <= '0;
         r_kf_s   <= '0;
         r_amp_s  <= '0;
         r_pstart <= 1'b0;
      end else begin
         r_run    <= w_run_nxt;
         r_cnt    <= w_cnt_nxt;
         r_state  <= w_state_nxt;
         r_val    <= w_val_nxt;
         r_per_s  <= w_per_nxt;
         r_on_s   <= w_on_nxt;
         r_kr_s   <= w_kr_nxt;
         r_kf_s   <= w_kf_nxt;
         r_amp_s  <= w_amp_nxt;
         r_pstart <= w_pstart_nxt;
      end
   end

   always_comb begin
      w_run_nxt    = r_run;
      w_cnt_nxt    = r_cnt;
      w_state_nxt  = r_state;
      w_val_nxt    = r_val;
      w_per_nxt    = r_per_s;
      w_on_nxt     = r_on_s;
      w_kr_nxt     = r_kr_s;
      w_kf_nxt     = r_kf_s;
      w_amp_nxt    = r_amp_s;
      // The pulse is rebuilt every clk, so it self-clears even between ticks.
      w_pstart_nxt = 1'b0;

      if (clk_en_i) begin
         if (w_load) begin
            w_per_nxt    = (period_i < CW'(2)) ? CW'(2) : period_i;
            w_on_nxt     = (on_time_i == '0) ? CW'(1) : on_time_i;
            w_kr_nxt     = k_rise_i;
            w_kf_nxt     = k_fall_i;
            w_amp_nxt    = amplitude_i;
            w_state_nxt  = ST_RISE;
            w_val_nxt    = '0;
            w_cnt_nxt    = CW'(1);
            w_run_nxt    = 1'b1;
            w_pstart_nxt = 1'b1;
         end else if (r_run) begin
            if (w_end) begin
               // End of period wins over everything; cnt=0 makes the next
               // tick a load tick unless the run is stopping here.
               w_val_nxt   = '0;
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               if (one_shot_i || !enable_i) begin
                  w_run_nxt = 1'b0;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
               if (w_force_fall || (r_state == ST_FALL)) begin
                  if (w_sum_le0) begin
                     w_val_nxt   = '0;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_val_nxt   = w_sum[WW-1:0];
                     w_state_nxt = ST_FALL;
                  end
               end else begin
                  case (r_state)
                     ST_RISE: begin
                        if (w_sum_ge_amp) begin
                           w_val_nxt   = r_amp_s;
                           w_state_nxt = ST_ON;
                        end else begin
                           w_val_nxt = w_sum[WW-1:0];
                        end
                     end
                     ST_ON:   w_val_nxt = r_amp_s;
                     default: w_val_nxt = '0;
                  endcase
               end
            end
         end
      end
   end

   assign out_o          = $signed({1'b0, r_val});
   assign state_o        = r_state;
   assign busy_o         = r_run;
   assign period_start_o = r_pstart;

endmodule
